// File: rtl/mcycle_sequencer.sv
// Execute-stage sequencer for the multi-cycle mul/div unit: launches, stalls EX until the result returns, selects the RV32M word.
// Miss costs 2+N stall cycles (N = UnitStart..UnitDone); a one-entry result cache lets paired ops hit with zero stall.
module mcycle_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MCycleStartE,
    input  logic [1:0]       MCycleOpE,
    input  logic [2:0]       Funct3E,
    input  logic             FlushE,
    input  logic [WIDTH-1:0] Operand1E,
    input  logic [WIDTH-1:0] Operand2E,
    output logic             UnitStart,
    output logic [1:0]       UnitOp,
    output logic [WIDTH-1:0] UnitOperand1,
    output logic [WIDTH-1:0] UnitOperand2,
    input  logic             UnitDone,
    input  logic [WIDTH-1:0] UnitResult1,
    input  logic [WIDTH-1:0] UnitResult2,
    output logic             StallMC,
    output logic [WIDTH-1:0] MCResultE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             cache_vld;
    logic [1:0]       cache_op;
    logic [WIDTH-1:0] cache_opa;
    logic [WIDTH-1:0] cache_opb;
    logic [WIDTH-1:0] cache_res1;
    logic [WIDTH-1:0] cache_res2;

    logic             hit;
    logic             launch;
    logic             cache_wr;
    logic             stall;
    logic             start_pulse;
    logic             sel_hi;

    assign hit = cache_vld && (cache_op == MCycleOpE) &&
                 (cache_opa == Operand1E) && (cache_opb == Operand2E);

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        cache_wr    = 1'b0;
        stall       = 1'b0;
        start_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                if (MCycleStartE && !hit && !FlushE) begin
                    launch    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            // The unit cannot be cancelled, so the pulse goes out even when flushed.
            S_LAUNCH: begin
                start_pulse = 1'b1;
                stall       = 1'b1;
                if (UnitDone) begin
                    cache_wr  = 1'b1;
                    state_nxt = FlushE ? S_IDLE : S_DONE;
                end else begin
                    state_nxt = FlushE ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (UnitDone) begin
                    cache_wr  = 1'b1;
                    state_nxt = FlushE ? S_IDLE : S_DONE;
                end else if (FlushE) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            // Squashed op still in flight: only a new MCycle instruction has to wait for it.
            S_DRAIN: begin
                stall = MCycleStartE;
                if (UnitDone) begin
                    cache_wr  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            UnitOp       <= 2'b00;
            UnitOperand1 <= '0;
            UnitOperand2 <= '0;
        end else if (launch) begin
            UnitOp       <= MCycleOpE;
            UnitOperand1 <= Operand1E;
            UnitOperand2 <= Operand2E;
        end
    end

    // Key comes from the launched copy, since EX may hold a different instruction by now.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cache_vld  <= 1'b0;
            cache_op   <= 2'b00;
            cache_opa  <= '0;
            cache_opb  <= '0;
            cache_res1 <= '0;
            cache_res2 <= '0;
        end else if (cache_wr) begin
            cache_vld  <= 1'b1;
            cache_op   <= UnitOp;
            cache_opa  <= UnitOperand1;
            cache_opb  <= UnitOperand2;
            cache_res1 <= UnitResult1;
            cache_res2 <= UnitResult2;
        end
    end

    always_comb begin
        if (!Funct3E[2]) begin
            sel_hi = (Funct3E[1:0] != 2'b00);
        end else begin
            sel_hi = Funct3E[1];
        end
        MCResultE = sel_hi ? cache_res2 : cache_res1;
    end

    assign UnitStart = start_pulse & ~RESET;
    assign StallMC   = stall & ~RESET;

endmodule
